// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter
// and other round-robin blocks built on the same picker.
package wrr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index of the highest set bit; callers pass a one-hot vector (up to 32 bits).
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of vec searching
// ptr+1, ptr+2, ... with wrap, ptr itself checked last.
module rr_priority_picker #(
  parameter int NUM_CH   = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]   vec,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [NUM_CH-1:0]   onehot,
  output logic [ID_WIDTH-1:0] index
);

  logic [NUM_CH-1:0] rot;
  int                first;

  always_comb begin
    rot = '0;
    // rot[0] is the channel just after ptr, so find-first gives rotating priority
    for (int k = 0; k < NUM_CH; k++) begin
      rot[k] = vec[ID_WIDTH'((int'(ptr) + 1 + k) % NUM_CH)];
    end
    found = |rot;
    first = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    index  = found ? ID_WIDTH'((int'(ptr) + 1 + first) % NUM_CH) : '0;
    onehot = '0;
    if (found) onehot[index] = 1'b1;
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Packet-aware weighted round-robin arbiter: grants are held for a whole
// packet and each completed packet costs the winning channel one credit.
module wrr_pkt_arbiter
  import wrr_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CREDIT_WIDTH = 4,
  parameter int ID_WIDTH     = clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*CREDIT_WIDTH-1:0] weights,
  input  logic                           credit_load,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              req_last,
  input  logic                           ack,
  output logic [NUM_CH-1:0]              grant,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy,
  output logic [NUM_CH-1:0]              credit_avail
);

  // Handshake: a beat moves when grant[i] & req[i] & ack; it ends the
  // packet when req_last[i] is also high. Nothing else releases a grant.

  state_e                               state_q, state_d;
  logic [NUM_CH-1:0]                    grant_q, grant_d;
  logic [ID_WIDTH-1:0]                  grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]                  ptr_q, ptr_d;
  logic [NUM_CH-1:0][CREDIT_WIDTH-1:0]  credit_q, credit_d;
  logic [NUM_CH-1:0][CREDIT_WIDTH-1:0]  weight_w;

  logic [NUM_CH-1:0]   enabled, active, eligible;
  logic                pick_found;
  logic [NUM_CH-1:0]   pick_onehot;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [ID_WIDTH-1:0] cur_idx;
  logic                pkt_end;

  assign weight_w = weights;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      enabled[i]      = weight_w[i] != '0;
      credit_avail[i] = credit_q[i] != '0;
    end
  end

  assign active   = req & enabled;
  assign eligible = active & credit_avail;

  rr_priority_picker #(
    .NUM_CH   (NUM_CH),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .vec    (eligible),
    .ptr    (ptr_q),
    .found  (pick_found),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  assign cur_idx = ID_WIDTH'(onehot_to_idx(32'(grant_q)));
  assign pkt_end = (state_q == BUSY) && ack && (|(grant_q & req & req_last));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          ptr_d      = pick_idx;
          state_d    = BUSY;
        end else if (|active) begin
          // Someone enabled wants service but all credit is spent: refill.
          credit_d = weight_w;
        end
      end
      BUSY: begin
        if (pkt_end) begin
          if (credit_q[cur_idx] != '0) begin
            credit_d[cur_idx] = credit_q[cur_idx] - CREDIT_WIDTH'(1);
          end
          grant_d    = '0;
          grant_id_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (credit_load) credit_d = weight_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_WIDTH'(NUM_CH - 1);
      credit_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Self-checking bench for wrr_pkt_arbiter: expected grant ids are queued
// as stimulus is set up and popped when the DUT issues each grant.
module tb_wrr_pkt_arbiter;

  localparam int NUM_CH = 4;
  localparam int CW     = 4;
  localparam int ID_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH*CW-1:0] weights = '0;
  logic                 credit_load = 1'b0;
  logic [NUM_CH-1:0]    req = '0;
  logic [NUM_CH-1:0]    req_last = '0;
  logic                 ack = 1'b0;
  logic [NUM_CH-1:0]    grant;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic [NUM_CH-1:0]    credit_avail;

  logic [ID_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wrr_pkt_arbiter #(
    .NUM_CH       (NUM_CH),
    .CREDIT_WIDTH (CW),
    .ID_WIDTH     (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .weights      (weights),
    .credit_load  (credit_load),
    .req          (req),
    .req_last     (req_last),
    .ack          (ack),
    .grant        (grant),
    .grant_id     (grant_id),
    .busy         (busy),
    .credit_avail (credit_avail)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: grant=%b id=%0d busy=%b want 0000/0/0", grant, grant_id, busy);
    end
    n_vec++;
    if (credit_avail !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_credit: credit_avail=%b want 0000", credit_avail);
    end
  endtask

  task automatic test_rotation();
    int cyc = 0;
    int last = 0;
    int eg;
    int gap_q[$];
    logic [NUM_CH-1:0] prev = '0;
    logic [ID_W-1:0] e;
    weights = 16'h1111; req = 4'hF; req_last = 4'hF; ack = 1'b1;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        exp_q.push_back(ID_W'(i));
        gap_q.push_back((i == 0) ? ((r == 0) ? 2 : 3) : 2);
      end
    end
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (grant !== '0 && prev === '0) begin
        e  = exp_q.pop_front();
        eg = gap_q.pop_front();
        n_vec++;
        if (grant_id !== e || grant !== (NUM_CH'(1) << e) || busy !== 1'b1) begin
          n_err++;
          $display("FAIL rot_grant: id=%0d grant=%b busy=%b want id=%0d", grant_id, grant, busy, e);
        end
        n_vec++;
        if (cyc - last != eg) begin
          n_err++;
          $display("FAIL rot_gap: gap=%0d want %0d", cyc - last, eg);
        end
        last = cyc;
      end
      prev = grant;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rot_timeout: %0d grants missing", exp_q.size());
    end
  endtask

  task automatic test_weighted();
    int cyc = 0;
    int cnt0 = 0;
    int cnt1 = 0;
    logic [NUM_CH-1:0] prev = '0;
    logic [ID_W-1:0] e;
    weights = 16'h0013; req = 4'b0011; req_last = 4'b0011; ack = 1'b1;
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    for (int r = 0; r < 9; r++) begin
      exp_q.push_back(2'd1); exp_q.push_back(2'd0);
      exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    end
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (grant !== '0 && prev === '0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (grant_id !== e) begin
          n_err++;
          $display("FAIL wrr_seq: id=%0d want %0d", grant_id, e);
        end
        if (grant_id == 2'd0) cnt0++;
        if (grant_id == 2'd1) cnt1++;
      end
      prev = grant;
    end
    n_vec++;
    if (cnt0 != 30 || cnt1 != 10) begin
      n_err++;
      $display("FAIL wrr_ratio: ch0=%0d ch1=%0d want 30/10", cnt0, cnt1);
    end
  endtask

  task automatic test_multibeat();
    int n = 0;
    int beats = 0;
    logic [ID_W-1:0] e;
    weights = 16'h0013; req = 4'b0001; req_last = 4'b0000; ack = 1'b0;
    do_reset();
    while (grant !== 4'b0001 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++;
      $display("FAIL mb_first_grant: grant=%b want 0001", grant);
    end
    exp_q.push_back(2'd1);
    n = 0;
    while (beats < 4 && n < 40) begin
      n_vec++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL mb_hold: grant=%b busy=%b after %0d beats want 0001/1", grant, busy, beats);
      end
      ack      = ~ack;
      req_last = (beats == 3) ? 4'b0001 : 4'b0000;
      if (beats >= 2) req[1] = 1'b1;
      @(negedge clk);
      n++;
      if (ack) beats++;
    end
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mb_release: grant=%b busy=%b want 0000/0", grant, busy);
    end
    n_vec++;
    if (dut.credit_q[0] !== 4'd2) begin
      n_err++;
      $display("FAIL mb_credit: credit0=%0d want 2", dut.credit_q[0]);
    end
    req = 4'b0010; req_last = 4'b0010; ack = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++;
    if (grant !== 4'b0010 || grant_id !== e) begin
      n_err++;
      $display("FAIL mb_next_grant: grant=%b id=%0d want 0010/%0d", grant, grant_id, e);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_disabled();
    weights = 16'h3210; credit_load = 1'b1; req = 4'b0000; req_last = 4'b0001; ack = 1'b1;
    do_reset();
    @(negedge clk);
    credit_load = 1'b0;
    weights = 16'h0000;
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (grant !== 4'b0000 || busy !== 1'b0 || credit_avail !== 4'b1110) begin
        n_err++;
        $display("FAIL dis_idle: cyc=%0d grant=%b busy=%b credit_avail=%b want 0000/0/1110",
                 i, grant, busy, credit_avail);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_load_at_end();
    int n = 0;
    weights = 16'h0200; req = 4'b0100; req_last = 4'b0000; ack = 1'b0;
    do_reset();
    while (grant !== 4'b0100 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (grant !== 4'b0100 || credit_avail !== 4'b0100) begin
      n_err++;
      $display("FAIL ld_grant: grant=%b credit_avail=%b want 0100/0100", grant, credit_avail);
    end
    weights = 16'h0500; credit_load = 1'b1; ack = 1'b1; req_last = 4'b0100;
    @(negedge clk);
    credit_load = 1'b0; ack = 1'b0; req = 4'b0000; req_last = 4'b0000;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ld_release: grant=%b busy=%b want 0000/0", grant, busy);
    end
    n_vec++;
    if (dut.credit_q[2] !== 4'd5) begin
      n_err++;
      $display("FAIL ld_credit: credit2=%0d want 5", dut.credit_q[2]);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    logic [ID_W-1:0] e;
    weights = 16'h1111; req = 4'b1000; req_last = 4'b0000; ack = 1'b1;
    do_reset();
    while (grant !== 4'b1000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_err++;
      $display("FAIL rm_grant: grant=%b id=%0d want 1000/3", grant, grant_id);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL rm_async: grant=%b busy=%b id=%0d want 0000/0/0", grant, busy, grant_id);
    end
    @(negedge clk);
    req = 4'b1001;
    rst = 1'b0;
    exp_q.push_back(2'd0);
    n = 0;
    while (grant === 4'b0000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (grant_id !== e || grant !== 4'b0001 || n != 2) begin
      n_err++;
      $display("FAIL rm_restart: id=%0d grant=%b after %0d cycles want %0d/0001/2", grant_id, grant, n, e);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_weighted();
    test_multibeat();
    test_disabled();
    test_load_at_end();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wrr_pkt_arbiter.md
Name: wrr_pkt_arbiter

Overview:
- Packet-aware weighted round-robin arbiter for N requesters sharing one downstream sink.
- A rotating priority pointer replaces fixed low-index priority.
- Each grant is locked for a whole multi-beat packet.
- A channel's credit is charged once per completed packet, with runtime reload and per-channel disable (weight 0).
- Sits in front of shared buses or FIFO write ports in the common IP library.

Parameters:
- NUM_CH, 4, number of requesting channels (>=2).
- CREDIT_WIDTH, 4, width of each weight/credit field.
- ID_WIDTH, clog2(NUM_CH), width of grant_id.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- weights  in  NUM_CH*CREDIT_WIDTH  per-channel weight; channel i at bits [CREDIT_WIDTH*(i+1)-1 : CREDIT_WIDTH*i]; 0 disables the channel.
- credit_load  in  1  one-cycle strobe; reloads all credits from weights.
- req  in  NUM_CH  per-channel request; held while a packet is pending.
- req_last  in  NUM_CH  marks the final beat of channel i's packet.
- ack  in  1  downstream accepts the current beat.
- grant  out  NUM_CH  one-hot registered grant.
- grant_id  out  ID_WIDTH  binary index of the granted channel; 0 when idle.
- busy  out  1  high while a packet grant is held.
- credit_avail  out  NUM_CH  credit_q[i] != 0.

Behaviour:
- Async reset values: grant=0, grant_id=0, busy=0, credit_q[i]=0, ptr=NUM_CH-1 (so channel 0 is first in order), state=IDLE.
  - The first arbitration after reset therefore performs a reload.
- Derived signals: enabled[i] = weight[i] != 0; active = req & enabled; eligible = active & credit_avail.
- Beat transfer: grant[i] & req[i] & ack. Packet end: a beat transfer with req_last[i]=1.
- FSM state IDLE:
  - eligible != 0: pick the first set bit of eligible, searching ptr+1, ptr+2, ... with wrap, ptr last. Next cycle: grant = onehot(pick), grant_id = pick, busy = 1, ptr = pick, state = BUSY.
  - eligible == 0 and active != 0: reload credit_q from weights, stay IDLE, no grant. This is a one-cycle bubble.
  - active == 0: hold everything. Disabled channels are never granted and never trigger a reload.
- FSM state BUSY:
  - grant is held regardless of req or of other channels' activity.
  - req[g] low only stalls the packet; the grant is not dropped.
  - On packet end: credit_q[g] decrements by 1 (saturating at 0); next cycle grant=0, busy=0, state=IDLE.
  - Latency from packet end to the next grant is 2 cycles.
- Latency from req asserted in IDLE (with credit) to grant is 1 cycle.
- credit_load: credit_q <= weights on the next edge, in any state. It takes precedence over a same-cycle decrement and over an IDLE reload. It does not affect grant or ptr.
- weights may change at any time. Only reload or credit_load samples them. enabled[] uses live weights.
- Credit arithmetic is unsigned CREDIT_WIDTH and never wraps below 0.
- Reset asserted mid-packet: grant drops immediately (asynchronous) and all state returns to reset values.

Decomposition:
- Package wrr_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - clog2 function
  - onehot-to-index function
- Sub-module rr_priority_picker:
  - purely combinational
  - inputs: NUM_CH-bit vector, ptr
  - outputs: found flag, onehot, index
  - implemented as rotate, find-first, rotate back
  - reusable by future round-robin blocks

Test Plan:
1. NUM_CH=4, weights all 1, all req high, req_last=1, ack=1 after reset -> reload bubble, then grant_id sequence 0,1,2,3, reload bubble, 0,... with grants 2 cycles apart.
2. weights ch0=3 ch1=1, only ch0/ch1 requesting single-beat packets -> grant_id 0,1,0,0, bubble, 1,0,0,0; 3:1 ratio over 40 packets.
3. ch0 4-beat packet, ack toggling 1,0,1,0...; ch1 requests at beat 2 -> grant stays 4'b0001 until the 4th accepted beat; ch1 granted exactly 2 cycles after it; credit_q[0] decremented once.
4. weights ch0=0 others=0, only ch0 requesting -> grant stays 0, busy stays 0, no reload activity for 20 cycles.
5. credit_load asserted in the same cycle as ch2's packet end (credit 2) -> credit_q[2] equals weight (e.g. 5), not 1; grant releases normally.
6. rst asserted mid-packet of ch3 -> grant=0, busy=0 in the same cycle without a clock edge; after release, ch0 wins first if requesting.
